// File: rtl/wb_arbiter.sv
// =============================================================================
// Module   : wb_arbiter (with params_pkg)
// Brief    : Writeback-port arbiter, MEM > EX > ALU, registered RF write.
//            Define WB_AGING_EN to enable starvation aging.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package params_pkg;
    parameter int REGISTER_WIDTH = 5;
endpackage

module wb_arbiter #(
    parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      mem_req_i,
    input  logic                      ex_req_i,
    input  logic                      alu_req_i,
    input  logic [REGISTER_WIDTH-1:0] mem_wr_reg_i,
    input  logic [REGISTER_WIDTH-1:0] ex_wr_reg_i,
    input  logic [REGISTER_WIDTH-1:0] alu_wr_reg_i,
    input  logic [DATA_WIDTH-1:0]     mem_wr_data_i,
    input  logic [DATA_WIDTH-1:0]     ex_wr_data_i,
    input  logic [DATA_WIDTH-1:0]     alu_wr_data_i,
    output logic                      mem_allowed_wb_o,
    output logic                      ex_allowed_wb_o,
    output logic                      alu_allowed_wb_o,
    output logic                      rf_wr_en_o,
    output logic [REGISTER_WIDTH-1:0] rf_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     rf_wr_data_o
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("STARVE_LIMIT must be within 1..15");
    end

    // Bit 2 = MEM, bit 1 = EX, bit 0 = ALU; higher bit is the older instruction.
    logic [2:0] w_req;
    logic [2:0] w_grant;

    assign w_req = {mem_req_i, ex_req_i, alu_req_i};

    function automatic logic [2:0] pick(input logic [2:0] r);
        if (r[2])      return 3'b100;
        else if (r[1]) return 3'b010;
        else if (r[0]) return 3'b001;
        else           return 3'b000;
    endfunction

`ifdef WB_AGING_EN
    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic [2:0][3:0] wait_cnt_q;
    logic [2:0][3:0] wait_cnt_d;
    logic [2:0]      w_aged;

    always_comb begin
        w_aged     = '0;
        wait_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            w_aged[i] = w_req[i] && (wait_cnt_q[i] == c_starve_limit);
        end
        // Any aged requester beats every non-aged one; base priority breaks ties.
        w_grant = (|w_aged) ? pick(w_aged) : pick(w_req);
        for (int i = 0; i < 3; i++) begin
            if (w_req[i] && !w_grant[i]) begin
                wait_cnt_d[i] = (wait_cnt_q[i] == c_starve_limit) ? wait_cnt_q[i]
                                                                  : wait_cnt_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    always_comb begin
        w_grant = pick(w_req);
    end
`endif

    assign mem_allowed_wb_o = w_grant[2];
    assign ex_allowed_wb_o  = w_grant[1];
    assign alu_allowed_wb_o = w_grant[0];

    logic                      rf_wr_en_q,   rf_wr_en_d;
    logic [REGISTER_WIDTH-1:0] rf_wr_reg_q,  rf_wr_reg_d;
    logic [DATA_WIDTH-1:0]     rf_wr_data_q, rf_wr_data_d;

    // A grant to register 0 still retires the requester but never writes.
    always_comb begin
        rf_wr_en_d   = 1'b0;
        rf_wr_reg_d  = rf_wr_reg_q;
        rf_wr_data_d = rf_wr_data_q;
        if (w_grant[2]) begin
            rf_wr_en_d   = (mem_wr_reg_i != '0);
            rf_wr_reg_d  = mem_wr_reg_i;
            rf_wr_data_d = mem_wr_data_i;
        end else if (w_grant[1]) begin
            rf_wr_en_d   = (ex_wr_reg_i != '0);
            rf_wr_reg_d  = ex_wr_reg_i;
            rf_wr_data_d = ex_wr_data_i;
        end else if (w_grant[0]) begin
            rf_wr_en_d   = (alu_wr_reg_i != '0);
            rf_wr_reg_d  = alu_wr_reg_i;
            rf_wr_data_d = alu_wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_wr_en_q   <= 1'b0;
            rf_wr_reg_q  <= '0;
            rf_wr_data_q <= '0;
        end else begin
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_reg_q  <= rf_wr_reg_d;
            rf_wr_data_q <= rf_wr_data_d;
        end
    end

    assign rf_wr_en_o   = rf_wr_en_q;
    assign rf_wr_reg_o  = rf_wr_reg_q;
    assign rf_wr_data_o = rf_wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// =============================================================================
// Module   : tb_wb_arbiter
// Brief    : Scoreboard bench for wb_arbiter; expectations follow WB_AGING_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_wb_arbiter;

`ifdef WB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req = 1'b0, ex_req = 1'b0, alu_req = 1'b0;
    logic [4:0]  mem_reg = '0, ex_reg = '0, alu_reg = '0;
    logic [31:0] mem_data = '0, ex_data = '0, alu_data = '0;
    logic        mem_ok, ex_ok, alu_ok;
    logic        rf_en;
    logic [4:0]  rf_reg;
    logic [31:0] rf_data;

    wb_arbiter #(.REGISTER_WIDTH(5), .DATA_WIDTH(32), .STARVE_LIMIT(3)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_req_i(mem_req), .ex_req_i(ex_req), .alu_req_i(alu_req),
        .mem_wr_reg_i(mem_reg), .ex_wr_reg_i(ex_reg), .alu_wr_reg_i(alu_reg),
        .mem_wr_data_i(mem_data), .ex_wr_data_i(ex_data), .alu_wr_data_i(alu_data),
        .mem_allowed_wb_o(mem_ok), .ex_allowed_wb_o(ex_ok), .alu_allowed_wb_o(alu_ok),
        .rf_wr_en_o(rf_en), .rf_wr_reg_o(rf_reg), .rf_wr_data_o(rf_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          is_rf;
        logic [2:0]  g;
        logic        en;
        logic [4:0]  rg;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: compares every expectation that falls due in this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                if (e.due != cyc) begin
                    check({e.name, "_late"}, 64'(cyc), 64'(e.due));
                end else if (e.is_rf) begin
                    check({e.name, "_rf"}, {27'd0, rf_en, rf_reg, rf_data},
                          {27'd0, e.en, e.rg, e.data});
                end else begin
                    check({e.name, "_grant"}, 64'({mem_ok, ex_ok, alu_ok}), 64'(e.g));
                end
            end
        end
    end

    // Drives one cycle of requests and queues its grant and next-cycle RF result.
    task automatic apply(input string nm,
                         input logic mr, input logic [4:0] mg, input logic [31:0] md,
                         input logic er, input logic [4:0] eg, input logic [31:0] ed,
                         input logic ar, input logic [4:0] ag, input logic [31:0] ad,
                         input logic [2:0] x_g, input logic x_en,
                         input logic [4:0] x_reg, input logic [31:0] x_data);
        exp_t e;
        @(posedge clk);
        #1;
        mem_req = mr; mem_reg = mg; mem_data = md;
        ex_req  = er; ex_reg  = eg; ex_data  = ed;
        alu_req = ar; alu_reg = ag; alu_data = ad;
        e = '{due: cyc, is_rf: 1'b0, g: x_g, en: 1'b0, rg: '0, data: '0, name: nm};
        q.push_back(e);
        e = '{due: cyc + 1, is_rf: 1'b1, g: '0, en: x_en, rg: x_reg, data: x_data, name: nm};
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [4:0] x_reg, input logic [31:0] x_data);
        apply(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, x_reg, x_data);
    endtask

    initial begin
        #2;
        check("reset_en",   64'(rf_en),   64'd0);
        check("reset_reg",  64'(rf_reg),  64'd0);
        check("reset_data", 64'(rf_data), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        idle("idle0", 5'd0, 32'd0);
        apply("prio", 1, 5'd3, 32'h1111_1111, 1, 5'd4, 32'h2222_2222, 1, 5'd6, 32'h6666_6666,
              3'b100, 1'b1, 5'd3, 32'h1111_1111);
        apply("x0", 0, 0, 0, 0, 0, 0, 1, 5'd0, 32'h55,
              3'b001, 1'b0, 5'd0, 32'h55);
        apply("ex_dead", 0, 0, 0, 1, 5'd7, 32'hDEAD, 0, 0, 0,
              3'b010, 1'b1, 5'd7, 32'hDEAD);
        idle("hold1", 5'd7, 32'hDEAD);
        idle("hold2", 5'd7, 32'hDEAD);
        apply("ex_alu", 0, 0, 0, 1, 5'd9, 32'h99, 1, 5'd10, 32'hA0,
              3'b010, 1'b1, 5'd9, 32'h99);
        idle("clr", 5'd9, 32'h99);

        for (int i = 0; i < 5; i++) begin
            if (AGING && i == 3)
                apply("aging", 1, 5'd1, 32'hA1, 0, 0, 0, 1, 5'd2, 32'hA2,
                      3'b001, 1'b1, 5'd2, 32'hA2);
            else
                apply("aging", 1, 5'd1, 32'hA1, 0, 0, 0, 1, 5'd2, 32'hA2,
                      3'b100, 1'b1, 5'd1, 32'hA1);
        end

        for (int i = 0; i < 2; i++)
            apply("flush_deny", 1, 5'd11, 32'hB1, 1, 5'd12, 32'hB2, 0, 0, 0,
                  3'b100, 1'b1, 5'd11, 32'hB1);
        idle("flush_drop", 5'd11, 32'hB1);
        for (int i = 0; i < 4; i++) begin
            if (AGING && i == 3)
                apply("post_flush", 1, 5'd13, 32'hC1, 1, 5'd14, 32'hC2, 0, 0, 0,
                      3'b010, 1'b1, 5'd14, 32'hC2);
            else
                apply("post_flush", 1, 5'd13, 32'hC1, 1, 5'd14, 32'hC2, 0, 0, 0,
                      3'b100, 1'b1, 5'd13, 32'hC1);
        end

        apply("rst_setup", 1, 5'd5, 32'h5555, 0, 0, 0, 0, 0, 0,
              3'b100, 1'b1, 5'd5, 32'h5555);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_en",    64'(rf_en),   64'd0);
        check("rst_async_reg",   64'(rf_reg),  64'd0);
        check("rst_async_data",  64'(rf_data), 64'd0);
        check("rst_grant_comb",  64'({mem_ok, ex_ok, alu_ok}), 64'(3'b100));
        @(posedge clk);
        #1;
        check("rst_held_en", 64'(rf_en), 64'd0);
        mem_req = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_no_write", {27'd0, rf_en, rf_reg, rf_data}, 64'd0);

        apply("post_rst", 1, 5'd5, 32'h77, 0, 0, 0, 0, 0, 0,
              3'b100, 1'b1, 5'd5, 32'h77);
        idle("end", 5'd5, 32'h77);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter REGISTER_WIDTH, default params_pkg::REGISTER_WIDTH, destination register index width.
REQ-002 Parameter DATA_WIDTH, default 32, writeback data width.
REQ-003 Parameter STARVE_LIMIT, default 3, consecutive denied cycles before a requester is aged (range 1..15).
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 mem_req_i / ex_req_i / alu_req_i  input  1 each  requester holds a finished instruction wanting the register-file write port.
REQ-007 mem_wr_reg_i / ex_wr_reg_i / alu_wr_reg_i  input  REGISTER_WIDTH each  destination register.
REQ-008 mem_wr_data_i / ex_wr_data_i / alu_wr_data_i  input  DATA_WIDTH each  result data.
REQ-009 mem_allowed_wb_o / ex_allowed_wb_o / alu_allowed_wb_o  output  1 each  same-cycle grant, consumed as the EX/ALU writeback-allowed inputs of the hazard unit.
REQ-010 rf_wr_en_o  output  1  registered register-file write enable.
REQ-011 rf_wr_reg_o  output  REGISTER_WIDTH  registered write index.
REQ-012 rf_wr_data_o  output  DATA_WIDTH  registered write data.

Function
REQ-013 At most one *_allowed_wb_o SHALL be high per cycle, and only for a requester whose *_req_i is high.
REQ-014 Grant logic SHALL be combinational from requests and aging state; no request-to-grant latency.
REQ-015 Base priority SHALL be MEM > EX > ALU (oldest instruction first).
REQ-016 If any request is high, exactly one grant SHALL be issued (work-conserving).
REQ-017 The granted request SHALL be captured at the next rising edge; rf_wr_en_o/reg/data SHALL reflect it for exactly one cycle (latency 1).
REQ-018 rf_wr_en_o SHALL be 0 when the granted wr_reg is 0; the grant still SHALL be issued so the requester retires.
REQ-019 With no requests, rf_wr_en_o SHALL be 0 next cycle; rf_wr_reg_o/rf_wr_data_o SHALL hold their previous values.
REQ-020 A denied requester SHALL keep its request and data stable until granted; the arbiter does not buffer denied requests.
REQ-021 Request dropped without grant (flush) SHALL be treated as withdrawn; no write occurs.

Reset
REQ-022 While rst_ni is low: rf_wr_en_o=0, rf_wr_reg_o=0, rf_wr_data_o=0, all aging counters=0, immediately and asynchronously.
REQ-023 Grant outputs SHALL stay combinational during reset; the sequencing registers SHALL ignore them until rst_ni deasserts.
REQ-024 Reset asserted in the same cycle as a grant SHALL discard that write; no write after deassertion without a new request.

Configuration
REQ-025 Macro WB_AGING_EN SHALL enable starvation protection; absent, arbitration is strictly REQ-015 with no counters synthesized.
REQ-026 With WB_AGING_EN: per-requester wait counter increments (saturating at STARVE_LIMIT) each cycle request-high-and-denied; clears when granted or request low.
REQ-027 With WB_AGING_EN: a requester whose counter equals STARVE_LIMIT is aged and SHALL outrank all non-aged requesters; ties among aged requesters resolved by REQ-015.

Verification
REQ-028 Reset: rst_ni=0 mid-grant with mem_req_i=1, wr_reg=5 -> rf_wr_en_o=0 immediately, no write on deassertion.
REQ-029 Priority: mem, ex, alu request together, regs 3/4/6 -> mem_allowed_wb_o=1 only; next cycle rf_wr_en_o=1, rf_wr_reg_o=3.
REQ-030 x0 write: only alu_req_i=1, alu_wr_reg_i=0 -> alu_allowed_wb_o=1; next cycle rf_wr_en_o=0.
REQ-031 Idle hold: single ex write reg 7 data 0xDEAD then no requests -> rf_wr_en_o=1 one cycle, then 0 with rf_wr_reg_o=7 held.
REQ-032 Aging (WB_AGING_EN, STARVE_LIMIT=3): mem_req_i and alu_req_i held high 5 cycles -> grants mem, mem, mem, alu, mem; without macro -> mem all 5 cycles.
REQ-033 Flush: ex_req_i high denied 2 cycles then dropped -> no ex write; with WB_AGING_EN ex counter returns to 0.
